// File: rtl/axis_frame_gen.sv
// AXI-Stream test traffic source: emits a run of fixed-length frames with a
// deterministic byte pattern, an optional inter-frame gap and run status.
module axis_frame_gen #(
  parameter int DATA_W  = 256,
  parameter int MIN_LEN = 64
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  START,
  input  logic                  STOP,
  input  logic [15:0]           FRAME_LEN,
  input  logic [31:0]           FRAME_CNT,
  input  logic [7:0]            IFG_BEATS,
  output logic [DATA_W-1:0]     M_AXIS_TDATA,
  output logic [DATA_W/8-1:0]   M_AXIS_TKEEP,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [31:0]           FRAMES_SENT
);

  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t      state, state_nxt;
  logic [4:0]  rem_r;        // len mod 32, selects the last-beat keep mask
  logic [15:0] last_beat_r;  // index of the final beat of each frame
  logic [31:0] cnt_r;
  logic [7:0]  ifg_r;
  logic [31:0] frame_idx;
  logic [15:0] beat_idx;
  logic [7:0]  gap_cnt;
  logic [31:0] frames_sent;
  logic        done_r;
  logic [15:0] len_c;
  logic        hs, is_last, more;

  // Keep mask of the final beat; a zero remainder means a full beat.
  function automatic logic [KEEP_W-1:0] last_keep(input logic [4:0] rem);
    if (rem == 5'd0) return '1;
    return (KEEP_W'(1) << rem) - KEEP_W'(1);
  endfunction

  // Payload of one beat: frame index in bytes 0..3 of beat 0, otherwise
  // (byte offset + frame index) mod 256; disabled bytes forced to zero.
  function automatic logic [DATA_W-1:0] beat_data(input logic [15:0] beat,
                                                  input logic [31:0] f,
                                                  input logic [KEEP_W-1:0] keep);
    logic [DATA_W-1:0] d;
    logic [31:0]       fsh;
    logic [7:0]        b;
    d = '0;
    for (int j = 0; j < KEEP_W; j++) begin
      fsh = f >> (8 * (j % 4));
      if (beat == 16'd0 && j < 4) b = fsh[7:0];
      else b = {beat[2:0], 5'b0} + 8'(j) + f[7:0];
      if (keep[j]) d[8*j +: 8] = b;
    end
    return d;
  endfunction

  assign len_c = (FRAME_LEN < 16'(MIN_LEN)) ? 16'(MIN_LEN) : FRAME_LEN;

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and stream outputs derived from the beat/frame counters.
  always_comb begin
    state_nxt     = state;
    is_last       = (beat_idx == last_beat_r);
    hs            = (state == S_SEND) && M_AXIS_TREADY;
    more          = (frame_idx + 32'd1) < cnt_r;
    M_AXIS_TVALID = (state == S_SEND);
    M_AXIS_TLAST  = 1'b0;
    M_AXIS_TKEEP  = '0;
    M_AXIS_TDATA  = '0;
    case (state)
      S_IDLE: if (START && FRAME_CNT != 32'd0) state_nxt = S_SEND;
      S_SEND: begin
        if (hs && is_last) begin
          if (!more || STOP)     state_nxt = S_IDLE;
          else if (ifg_r != 8'd0) state_nxt = S_GAP;
          else                    state_nxt = S_SEND;
        end
      end
      S_GAP:  if (gap_cnt <= 8'd1) state_nxt = S_SEND;
      default: state_nxt = S_IDLE;
    endcase
    if (M_AXIS_TVALID) begin
      M_AXIS_TLAST = is_last;
      M_AXIS_TKEEP = is_last ? last_keep(rem_r) : '1;
      M_AXIS_TDATA = beat_data(beat_idx, frame_idx, M_AXIS_TKEEP);
    end
  end

  // Run parameters, beat/frame counters, gap timer and DONE pulse.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rem_r       <= '0;
      last_beat_r <= '0;
      cnt_r       <= '0;
      ifg_r       <= '0;
      frame_idx   <= '0;
      beat_idx    <= '0;
      gap_cnt     <= '0;
      frames_sent <= '0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            rem_r       <= len_c[4:0];
            last_beat_r <= (len_c - 16'd1) >> 5;
            cnt_r       <= FRAME_CNT;
            ifg_r       <= IFG_BEATS;
            frame_idx   <= '0;
            beat_idx    <= '0;
            frames_sent <= '0;
            if (FRAME_CNT == 32'd0) done_r <= 1'b1;
          end
        end
        S_SEND: begin
          if (hs) begin
            if (is_last) begin
              beat_idx    <= '0;
              frame_idx   <= frame_idx + 32'd1;
              frames_sent <= frames_sent + 32'd1;
              if (state_nxt == S_IDLE) done_r <= 1'b1;
              if (state_nxt == S_GAP)  gap_cnt <= ifg_r;
            end else begin
              beat_idx <= beat_idx + 16'd1;
            end
          end
        end
        S_GAP:   gap_cnt <= gap_cnt - 8'd1;
        default: ;
      endcase
    end
  end

  assign BUSY        = (state != S_IDLE);
  assign DONE        = done_r;
  assign FRAMES_SENT = frames_sent;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed bench for axis_frame_gen: frame shape, payload, gaps, backpressure,
// clamp, zero count, STOP and mid-frame reset.
module tb_axis_frame_gen;

  logic         clk = 1'b0;
  logic         ARESET, START, STOP, TREADY;
  logic [15:0]  FRAME_LEN;
  logic [31:0]  FRAME_CNT;
  logic [7:0]   IFG_BEATS;
  logic [255:0] TDATA;
  logic [31:0]  TKEEP;
  logic         TVALID, TLAST, BUSY, DONE;
  logic [31:0]  FRAMES_SENT;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axis_frame_gen dut (
    .ACLK(clk), .ARESET(ARESET), .START(START), .STOP(STOP),
    .FRAME_LEN(FRAME_LEN), .FRAME_CNT(FRAME_CNT), .IFG_BEATS(IFG_BEATS),
    .M_AXIS_TDATA(TDATA), .M_AXIS_TKEEP(TKEEP), .M_AXIS_TVALID(TVALID),
    .M_AXIS_TREADY(TREADY), .M_AXIS_TLAST(TLAST),
    .BUSY(BUSY), .DONE(DONE), .FRAMES_SENT(FRAMES_SENT)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected beat contents, built byte by byte from the byte offset k.
  function automatic logic [255:0] exp_data(input int len, input int f, input int b);
    logic [255:0] d;
    int k;
    d = '0;
    for (int j = 0; j < 32; j++) begin
      k = b * 32 + j;
      if (k < len) begin
        if (k < 4) d[8*j +: 8] = 8'((f >> (8 * k)) & 255);
        else       d[8*j +: 8] = 8'((k + f) % 256);
      end
    end
    return d;
  endfunction

  function automatic logic [31:0] exp_keep(input int len, input int b);
    int nb, rem;
    nb  = (len + 31) / 32;
    rem = len % 32;
    if (b < nb - 1 || rem == 0) return 32'hFFFF_FFFF;
    return (32'd1 << rem) - 32'd1;
  endfunction

  // Launch one run and follow it beat by beat against the model.
  task automatic run(input int len_in, input int cnt, input int ifg, input bit rnd,
                     input int stop_frame, output int beats0, output logic [31:0] lastkeep0,
                     output logic [7:0] b4f0, output logic [7:0] b4f1);
    int len, nb, f, b, gap, done_cnt, cyc, post, exp_frames;
    logic prev_stall, sl;
    logic [255:0] sd;
    logic [31:0] sk;
    len = (len_in < 64) ? 64 : len_in;
    nb  = (len + 31) / 32;
    exp_frames = cnt;
    if (stop_frame >= 0 && stop_frame < cnt) exp_frames = stop_frame + 1;
    f = 0; b = 0; gap = 0; done_cnt = 0; cyc = 0; post = -1;
    prev_stall = 1'b0; sl = 1'b0; sd = '0; sk = '0;
    beats0 = 0; lastkeep0 = '0; b4f0 = '0; b4f1 = '0;
    FRAME_LEN = 16'(len_in); FRAME_CNT = 32'(cnt); IFG_BEATS = 8'(ifg);
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    while (cyc < 20000 && post != 0) begin
      if (stop_frame >= 0 && f == stop_frame && b == 1) STOP = 1'b1;
      TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) check("tvalid_hold", TVALID, 1'b1);
      if (TVALID) begin
        if (f >= exp_frames) begin
          check("beat_after_end", TVALID, 1'b0);
        end else begin
          if (prev_stall) begin
            check("stall_data", TDATA, sd);
            check("stall_keep", TKEEP, sk);
            check("stall_last", TLAST, sl);
          end
          if (b == 0 && f > 0 && !prev_stall) begin
            check("ifg", gap, ifg);
            gap = 0;
          end
          check("data", TDATA, exp_data(len, f, b));
          check("keep", TKEEP, exp_keep(len, b));
          check("last", TLAST, b == nb - 1);
          check("busy", BUSY, 1'b1);
          if (f == 0 && b == 0) b4f0 = TDATA[39:32];
          if (f == 1 && b == 0) b4f1 = TDATA[39:32];
          if (f == 0 && b == nb - 1) lastkeep0 = TKEEP;
          if (f == 0 && TREADY) beats0++;
          sd = TDATA; sk = TKEEP; sl = TLAST;
          prev_stall = !TREADY;
          if (TREADY) begin
            if (b == nb - 1) begin b = 0; f++; end
            else b++;
          end
        end
      end else begin
        prev_stall = 1'b0;
        if (BUSY && f > 0) gap++;
      end
      if (DONE) begin
        done_cnt++;
        check("busy_at_done", BUSY, 1'b0);
        if (cnt == 0) check("zero_done_cyc", cyc, 0);
        if (post < 0) post = 4;
      end
      if (post > 0) post--;
      @(negedge clk);
      cyc++;
    end
    if (post != 0) check("run_timeout", cyc, 0);
    check("frames_seen", f, exp_frames);
    check("frames_sent", FRAMES_SENT, exp_frames);
    check("done_pulses", done_cnt, 1);
    check("busy_end", BUSY, 1'b0);
    STOP = 1'b0;
  endtask

  initial begin
    int bt;
    logic [31:0] lk;
    logic [7:0] x0, x1;
    bit found;
    ARESET = 1'b1; START = 1'b0; STOP = 1'b0; TREADY = 1'b1;
    FRAME_LEN = '0; FRAME_CNT = '0; IFG_BEATS = '0;
    repeat (3) @(negedge clk);
    check("rst_tvalid", TVALID, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_sent", FRAMES_SENT, 32'd0);
    check("rst_data", {TDATA, TKEEP, TLAST}, '0);
    ARESET = 1'b0;
    @(negedge clk);

    // Basic 64-byte frame.
    run(64, 1, 0, 1'b0, -1, bt, lk, x0, x1);
    check("basic_beats", bt, 2);
    check("basic_keep", lk, 32'hFFFF_FFFF);
    check("basic_byte4", x0, 8'h04);

    // 100-byte frames, gap of 3.
    run(100, 2, 3, 1'b0, -1, bt, lk, x0, x1);
    check("part_beats", bt, 4);
    check("part_keep", lk, 32'h0000_000F);
    check("part_f1_byte4", x1, 8'h05);

    // Backpressure, 257-byte frames.
    run(257, 5, 1, 1'b1, -1, bt, lk, x0, x1);
    check("bp_beats", bt, 9);
    check("bp_keep", lk, 32'h0000_0001);

    // Clamp and zero count.
    run(10, 1, 0, 1'b0, -1, bt, lk, x0, x1);
    check("clamp_beats", bt, 2);
    check("clamp_keep", lk, 32'hFFFF_FFFF);
    run(64, 0, 0, 1'b0, -1, bt, lk, x0, x1);
    check("zero_beats", bt, 0);

    // STOP during frame 3 of 100.
    run(100, 100, 2, 1'b0, 3, bt, lk, x0, x1);

    // Reset during beat 1 of frame 1 (4-beat frames).
    FRAME_LEN = 16'd128; FRAME_CNT = 32'd3; IFG_BEATS = 8'd0; TREADY = 1'b1;
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (TVALID && TDATA[7:0] == 8'd1) found = 1'b1;
      else @(negedge clk);
    end
    check("rst_wait_found", found, 1'b1);
    @(negedge clk);
    check("pre_rst_sent", FRAMES_SENT, 32'd1);
    check("pre_rst_beat1", TDATA[7:0], 8'd33);
    ARESET = 1'b1;
    @(negedge clk);
    ARESET = 1'b0;
    check("mid_rst_tvalid", TVALID, 1'b0);
    check("mid_rst_busy", BUSY, 1'b0);
    check("mid_rst_sent", FRAMES_SENT, 32'd0);
    check("mid_rst_last", TLAST, 1'b0);
    run(128, 1, 0, 1'b0, -1, bt, lk, x0, x1);
    check("restart_beats", bt, 4);
    check("restart_byte4", x0, 8'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_frame_gen.md
Name: axis_frame_gen

Overview:
- Upstream traffic source for the 256-bit AXI-Stream pass-through stage; drives its S_AXIS input.
- On START, emits FRAME_CNT frames of FRAME_LEN bytes each, with a deterministic byte pattern and a configurable inter-frame gap.
- Exposes BUSY, DONE and a sent-frame counter for the tester control logic.

Parameters:
- DATA_W, 256, stream data width in bits; fixed at 256, so TKEEP is 32 bits.
- MIN_LEN, 64, minimum frame length in bytes; smaller FRAME_LEN values are clamped up to this.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; begins a run; honoured only in IDLE.
- STOP  in  1  level; finish the current frame, then return to IDLE.
- FRAME_LEN  in  16  frame length in bytes; sampled on START.
- FRAME_CNT  in  32  frames per run; sampled on START.
- IFG_BEATS  in  8  idle cycles between frames; sampled on START.
- M_AXIS_TDATA  out  256  stream data; byte 0 is on [7:0].
- M_AXIS_TKEEP  out  32  byte enables.
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TLAST  out  1  last beat of frame.
- BUSY  out  1  run in progress.
- DONE  out  1  one-cycle pulse at end of run.
- FRAMES_SENT  out  32  completed frames in the current or last run.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. ARESET mid-frame aborts the frame and takes effect at the next edge. No TLAST is emitted and FRAMES_SENT clears.
- States and transitions:
  - IDLE -> SEND on START when FRAME_CNT != 0.
  - START with FRAME_CNT == 0: DONE pulses the next cycle and no frame is sent.
  - SEND -> GAP on a TLAST handshake when more frames remain, STOP is low and IFG_BEATS != 0.
  - SEND -> SEND for the next frame when IFG_BEATS == 0 (back-to-back frames).
  - SEND -> IDLE on a TLAST handshake when it was the final frame or STOP is high.
  - GAP -> SEND after exactly IFG_BEATS cycles with TVALID low.
- Latched values: len = max(FRAME_LEN, MIN_LEN).
- Beats per frame: ceil(len/32).
- TKEEP:
  - Non-last beats: 32'hFFFF_FFFF.
  - Last beat: (1 << (len mod 32)) - 1, or all ones when len mod 32 == 0.
  - Bytes with TKEEP=0 are driven 0.
- Payload: frame index f runs from 0 to FRAME_CNT-1, byte k runs from 0 to len-1.
  - Bytes 0..3 of beat 0 carry f, little-endian.
  - Every other byte k = (k + f) mod 256.
- Timing:
  - First TVALID asserts the cycle after START is accepted, so start latency is 1 cycle.
  - Each handshake (TVALID & TREADY) advances one beat.
  - With TREADY held high, one beat per cycle, no bubbles.
- Handshake rules:
  - Once TVALID is high, TDATA, TKEEP and TLAST stay stable until the handshake.
  - TVALID never drops without a handshake, except on ARESET.
- STOP: sampled at each TLAST handshake only; a frame is never truncated.
- START while BUSY: ignored.
- FRAMES_SENT:
  - Clears on an accepted START.
  - Increments on each TLAST handshake.
  - Holds after the run ends.
- BUSY: high from the cycle after START through the final TLAST handshake cycle.
- DONE: pulses the cycle after the final TLAST handshake, or after a STOP-terminated frame. BUSY is low in that cycle.
- Counters: the frame index wraps at 2^32 (unreachable in practice). Byte pattern arithmetic is mod 256.

Test Plan:
- Basic frame: FRAME_LEN=64, FRAME_CNT=1, IFG=0, TREADY=1.
  - Expect 2 beats, TKEEP all ones on both, TLAST on beat 2.
  - Beat 0 bytes 0..3 = 0; byte 4 = 0x04.
  - DONE pulses once; FRAMES_SENT=1.
- Partial last beat: FRAME_LEN=100, FRAME_CNT=2, IFG=3.
  - Expect 4 beats per frame; last TKEEP = 32'h0000_000F.
  - Exactly 3 TVALID-low cycles between frames.
  - Frame 1 byte 4 = 0x05; FRAMES_SENT=2.
- Backpressure: random TREADY (50%), FRAME_LEN=257, FRAME_CNT=5.
  - Outputs stay stable across every stall.
  - 9 beats per frame; last TKEEP = 32'h1; no lost or duplicated beat.
- Clamp and zero count:
  - FRAME_LEN=10 -> 64-byte frames.
  - FRAME_CNT=0 -> DONE the next cycle, TVALID never rises.
- STOP: FRAME_CNT=100, STOP raised mid-frame 3.
  - Frame 3 completes with TLAST, then IDLE; DONE pulses; FRAMES_SENT=4.
- Reset mid-frame: ARESET during beat 1 of a 4-beat frame.
  - Next cycle: TVALID=0, BUSY=0, FRAMES_SENT=0.
  - A new START restarts at frame index 0.
